// File: rtl/param_rotator_if.sv
// Bus bundle for param_rotator: load/op controls toward the rotator, result and status back.
interface param_rotator_if #(
    parameter int WIDTH = 100,
    parameter int AMT_W = 7
);
    logic             load;
    logic [WIDTH-1:0] data;
    logic [1:0]       ena;
    logic             start;
    logic             dir;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (output load, data, ena, start, dir, mode, amount,
                    input  q, busy, done);
    modport slave  (input  load, data, ena, start, dir, mode, amount,
                    output q, busy, done);
endinterface

// File: rtl/param_rotator.sv
// Multi-cycle rotator/shifter moving up to STEP positions per clock.
// Define PARAM_ROTATOR_SHIFT_MODES_EN to enable logical/arithmetic shift modes; otherwise all ops rotate.
module param_rotator #(
    parameter int WIDTH = 100,
    parameter int AMT_W = 7,
    parameter int STEP  = 1
) (
    input  logic            clk,
    input  logic            reset,
    param_rotator_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [AMT_W-1:0] rem, rem_nxt, m;
    logic [WIDTH-1:0] q, q_nxt, moved, rot_r, rot_l;
    logic             dir_r, dir_nxt;
    logic             done_r, done_nxt;

    // m never exceeds rem, so it always fits AMT_W even when STEP does not
    always_comb begin
        m = rem;
        if (32'(rem) > STEP) m = AMT_W'(STEP);
    end

    assign rot_r = WIDTH'({q, q} >> m);
    assign rot_l = WIDTH'(({q, q} << m) >> WIDTH);

`ifdef PARAM_ROTATOR_SHIFT_MODES_EN
    logic [1:0]       mode_r, mode_nxt;
    logic [WIDTH-1:0] shl, shr, sar;

    // Stepwise shifting saturates naturally once total amount reaches WIDTH
    assign shl = q << m;
    assign shr = q >> m;
    assign sar = WIDTH'($signed(q) >>> m);

    always_comb begin
        moved = dir_r ? rot_l : rot_r;
        case (mode_r)
            2'b01:   moved = dir_r ? shl : shr;
            2'b10:   moved = dir_r ? shl : sar;
            default: moved = dir_r ? rot_l : rot_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) mode_r <= 2'b00;
        else       mode_r <= mode_nxt;
    end
`else
    wire unused_mode = ^bus.mode;

    assign moved = dir_r ? rot_l : rot_r;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rem    <= '0;
            q      <= '0;
            dir_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            rem    <= rem_nxt;
            q      <= q_nxt;
            dir_r  <= dir_nxt;
            done_r <= done_nxt;
        end
    end

    // next-state
    always_comb begin
        state_nxt = state;
        if (bus.load)
            state_nxt = IDLE;
        else if (state == IDLE) begin
            if (bus.start && (bus.amount != '0)) state_nxt = RUN;
        end else if (rem == m)
            state_nxt = IDLE;
    end

    // datapath / outputs
    always_comb begin
        q_nxt    = q;
        rem_nxt  = rem;
        dir_nxt  = dir_r;
        done_nxt = 1'b0;
`ifdef PARAM_ROTATOR_SHIFT_MODES_EN
        mode_nxt = mode_r;
`endif
        if (bus.load) begin
            q_nxt   = bus.data;
            rem_nxt = '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                if (bus.amount == '0)
                    done_nxt = 1'b1;
                else begin
                    rem_nxt = bus.amount;
                    dir_nxt = bus.dir;
`ifdef PARAM_ROTATOR_SHIFT_MODES_EN
                    mode_nxt = bus.mode;
`endif
                end
            end else if (bus.ena == 2'b01)
                q_nxt = {q[0], q[WIDTH-1:1]};
            else if (bus.ena == 2'b10)
                q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        end else begin
            q_nxt    = moved;
            rem_nxt  = rem - m;
            done_nxt = (rem == m);
        end
    end

    assign bus.q    = q;
    assign bus.busy = (state == RUN);
    assign bus.done = done_r;
endmodule

// File: tb/tb_param_rotator.sv
// Scoreboard bench for param_rotator (WIDTH=8, AMT_W=4, STEP=2); expectations follow the macro setting.
module tb_param_rotator;
    localparam int W  = 8;
    localparam int AW = 4;
    localparam int ST = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    param_rotator_if #(.WIDTH(W), .AMT_W(AW)) bus ();
    param_rotator #(.WIDTH(W), .AMT_W(AW), .STEP(ST)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;
    int dones    = 0;
    int pushed   = 0;
    logic [W-1:0] expq[$];

`ifdef PARAM_ROTATOR_SHIFT_MODES_EN
    localparam logic [W-1:0] E_ASR9 = 8'hFF, E_SHL12 = 8'h00, E_ASL3 = 8'h18, E_LSR1 = 8'h01;
`else
    localparam logic [W-1:0] E_ASR9 = 8'h40, E_SHL12 = 8'h2B, E_ASL3 = 8'h1A, E_LSR1 = 8'h81;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [W-1:0] v);
        bus.load = 1'b1;
        bus.data = v;
        step();
        bus.load = 1'b0;
        chk("load_q", bus.q, v);
    endtask

    // Issue one op, count busy cycles; optionally wiggle inputs while busy
    task automatic op(input logic d, input logic [1:0] md, input logic [AW-1:0] amt,
                      input logic [W-1:0] eq, input int ebusy, input bit noise, input string name);
        int cnt = 0;
        bus.dir = d; bus.mode = md; bus.amount = amt; bus.start = 1'b1;
        expq.push_back(eq);
        pushed++;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cnt++;
            if (noise) begin
                bus.start = 1'b1; bus.dir = ~d; bus.mode = 2'b01; bus.amount = 4'd1; bus.ena = 2'b10;
            end
        end
        bus.start = 1'b0;
        bus.ena   = 2'b00;
        chk({name, "_busy_cycles"}, cnt, ebusy);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dones++;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: q=%0h with no pending op", bus.q);
                end else begin
                    chk("done_q", bus.q, expq.pop_front());
                    chk("done_busy", bus.busy, 0);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.load = 1'b0; bus.data = '0; bus.ena = 2'b00; bus.start = 1'b0;
        bus.dir = 1'b0; bus.mode = 2'b00; bus.amount = '0;
        step(); step();
        chk("rst_q", bus.q, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        reset = 1'b0;

        ld(8'b10010110);
        op(1'b1, 2'b00, 4'd3, 8'b10110100, 2, 1'b0, "rol3");

        ld(8'b10000000);
        op(1'b0, 2'b10, 4'd9, E_ASR9, 5, 1'b1, "asr9_noise");

        ld(8'hCA);
        op(1'b0, 2'b00, 4'd10, 8'hB2, 5, 1'b0, "ror10");
        op(1'b1, 2'b01, 4'd12, E_SHL12, 6, 1'b0, "shl12");

        ld(8'h43);
        op(1'b1, 2'b10, 4'd3, E_ASL3, 2, 1'b0, "asl3");

        ld(8'h07);
        op(1'b0, 2'b11, 4'd3, 8'hE0, 2, 1'b0, "ror3_mode11");

        ld(8'b00000011);
        op(1'b0, 2'b01, 4'd1, E_LSR1, 1, 1'b0, "lsr1");

        // free-run rotation in IDLE
        ld(8'b00000001);
        bus.ena = 2'b01;
        step();
        bus.ena = 2'b00;
        chk("ena_ror1", bus.q, 8'b10000000);
        bus.ena = 2'b10;
        step(); step();
        bus.ena = 2'b00;
        chk("ena_rol2", bus.q, 8'b00000010);
        chk("ena_busy", bus.busy, 0);

        // load aborts a run on its second RUN cycle
        ld(8'h3C);
        bus.dir = 1'b0; bus.mode = 2'b00; bus.amount = 4'd8; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("abort_busy_before", bus.busy, 1);
        step();
        bus.load = 1'b1; bus.data = 8'hA5;
        step();
        bus.load = 1'b0;
        chk("abort_q", bus.q, 8'hA5);
        chk("abort_busy", bus.busy, 0);
        repeat (10) step();

        // reset mid-run overrides load and start
        bus.amount = 4'd8; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        reset = 1'b1; bus.load = 1'b1; bus.data = 8'hFF; bus.start = 1'b1;
        step();
        chk("midrst_q", bus.q, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        reset = 1'b0; bus.load = 1'b0; bus.start = 1'b0;
        op(1'b0, 2'b00, 4'd0, 8'h00, 0, 1'b0, "amt0");

        repeat (3) step();
        chk("done_count", dones, pushed);
        chk("queue_empty", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
